// File: rtl/sc_sched_pkg.sv
// rtl/sc_sched_pkg.sv - shared types and width helpers for the SC neuron scheduler
package sc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WARM,
    RUN,
    DRAIN,
    REPORT
  } sched_state_t;

  function automatic int sel_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int warm_width(input int w);
    return (w > 0) ? $clog2(w + 1) : 1;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - ones accumulator for the shared neuron output stream
module sc_ones_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && bit_in) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sc_neuron_scheduler.sv
// rtl/sc_neuron_scheduler.sv - time-multiplexes one SC APC neuron across M logical neurons
module sc_neuron_scheduler
  import sc_sched_pkg::*;
#(
  parameter int M      = 4,
  parameter int LW     = 8,
  parameter int WARMUP = 16,
  localparam int SW    = sel_width(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [SW-1:0] neuron_sel,
  output logic          neu_reset,
  output logic          sng_en,
  input  logic          neu_dout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [LW:0]   res_data,
  output logic [SW-1:0] res_idx,
  output logic          frame_done
);

  localparam int WW = warm_width(WARMUP);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [SW-1:0] SEL_LAST  = SW'(M - 1);

  sched_state_t  state;
  logic [LW-1:0] win_cnt;
  logic [WW-1:0] warm_cnt;
  logic          sample_en;
  logic          sample_en_q;
  logic [LW:0]   count;

  assign sample_en = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      win_cnt     <= '0;
      warm_cnt    <= '0;
      neuron_sel  <= '0;
      sample_en_q <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // The neuron output is registered, so its sample lags the RUN window by one cycle.
      sample_en_q <= sample_en;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neuron_sel <= '0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          win_cnt  <= '0;
          warm_cnt <= '0;
          state    <= (WARMUP > 0) ? WARM : RUN;
        end
        WARM: begin
          warm_cnt <= warm_cnt + 1'b1;
          if (warm_cnt == WARM_LAST) state <= RUN;
        end
        RUN: begin
          win_cnt <= win_cnt + 1'b1;
          if (&win_cnt) state <= DRAIN;
        end
        DRAIN: state <= REPORT;
        REPORT: begin
          if (res_ready) begin
            if (neuron_sel != SEL_LAST) begin
              neuron_sel <= neuron_sel + 1'b1;
              state      <= CLEAR;
            end else begin
              neuron_sel <= '0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sc_ones_counter #(.W(LW + 1)) u_ones (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == CLEAR),
    .en     (sample_en_q),
    .bit_in (neu_dout),
    .count  (count)
  );

  assign busy      = (state != IDLE);
  assign neu_reset = (state == CLEAR);
  assign sng_en    = (state == WARM) || (state == RUN);
  assign res_valid = (state == REPORT);
  assign res_data  = res_valid ? count : '0;
  assign res_idx   = res_valid ? neuron_sel : '0;

endmodule

// File: tb/tb_sc_neuron_scheduler.sv
// tb/tb_sc_neuron_scheduler.sv - directed vector bench for sc_neuron_scheduler
module tb_sc_neuron_scheduler;

  logic       clk = 1'b0;
  logic       reset, start, neu_dout, res_ready, start0;
  logic       busy, neu_reset, sng_en, res_valid, frame_done;
  logic [1:0] neuron_sel, res_idx;
  logic [4:0] res_data;
  logic       busy0, neu_reset0, sng_en0, res_valid0, frame_done0;
  logic [0:0] neuron_sel0, res_idx0;
  logic [4:0] res_data0;

  always #5 clk = ~clk;

  sc_neuron_scheduler #(.M(4), .LW(4), .WARMUP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .neuron_sel(neuron_sel),
    .neu_reset(neu_reset), .sng_en(sng_en), .neu_dout(neu_dout), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx), .frame_done(frame_done)
  );

  sc_neuron_scheduler #(.M(1), .LW(4), .WARMUP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .neuron_sel(neuron_sel0),
    .neu_reset(neu_reset0), .sng_en(sng_en0), .neu_dout(1'b1), .res_valid(res_valid0),
    .res_ready(1'b1), .res_data(res_data0), .res_idx(res_idx0), .frame_done(frame_done0)
  );

  typedef struct {
    int mode;
    int exp;
    int wait_c;
    bit st_pulse;
  } vec_t;

  vec_t vecs[8];
  int   nchk = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Neuron-relative cycle c: 1 CLEAR, 2..3 WARM, 4..19 RUN, 20 DRAIN, 21 REPORT.
  function automatic logic pat(input int mode, input int c);
    case (mode)
      1:       return 1'b1;
      2:       return (c < 4) ? 1'b1 : (((c - 3) % 2) == 1);
      3:       return (c <= 4);
      4:       return (c == 20);
      5:       return (c >= 4 && c <= 7);
      6:       return (c == 19);
      7:       return (c != 20);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_neuron(input int mode, input int exp, input int idx, input int wait_c,
                            input bit st_pulse, input int abort_c, input bit last);
    logic [1:0] i2;
    i2 = idx[1:0];
    for (int c = 1; c <= 21; c++) begin
      neu_dout = pat(mode, c);
      start    = st_pulse && (c == 10);
      if (c == abort_c) begin
        #2 reset = 1'b1;
        #1;
        check("reset_outs", {busy, neuron_sel, neu_reset, sng_en, res_valid, res_data, res_idx, frame_done}, 0);
        start = 1'b0;
        return;
      end
      check($sformatf("ctrl_n%0d_c%0d", idx, c), {busy, neu_reset, sng_en, res_valid, neuron_sel},
            {1'b1, c == 1, (c >= 2 && c <= 19), c == 21, i2});
      if (c < 21) step();
    end
    start = 1'b0;
    check($sformatf("res_data_n%0d", idx), res_data, exp);
    check($sformatf("res_idx_n%0d", idx), res_idx, i2);
    res_ready = (wait_c == 0);
    for (int w = 1; w < wait_c; w++) begin
      step();
      check($sformatf("hold_n%0d_w%0d", idx, w), {res_valid, sng_en, res_data, res_idx}, {1'b1, 1'b0, exp[4:0], i2});
    end
    res_ready = 1'b1;
    step();
    if (last) begin
      check("frame_done_pulse", {frame_done, busy, neuron_sel, res_valid}, {1'b1, 1'b0, 2'd0, 1'b0});
      step();
      check("frame_done_clear", {frame_done, busy}, 0);
    end
  endtask

  initial begin
    int n;
    vec_t v;
    vecs[0] = '{0, 0, 0, 1'b0};
    vecs[1] = '{1, 16, 0, 1'b1};
    vecs[2] = '{2, 8, 10, 1'b0};
    vecs[3] = '{3, 0, 0, 1'b0};
    vecs[4] = '{4, 1, 0, 1'b0};
    vecs[5] = '{5, 3, 2, 1'b0};
    vecs[6] = '{6, 1, 0, 1'b0};
    vecs[7] = '{7, 15, 0, 1'b0};

    reset = 1'b1; start = 1'b0; start0 = 1'b0; neu_dout = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, neuron_sel, neu_reset, sng_en, res_valid, res_data, res_idx, frame_done}, 0);
    check("reset_state0", {busy0, neuron_sel0, neu_reset0, sng_en0, res_valid0, res_data0, res_idx0, frame_done0}, 0);
    reset = 1'b0;
    step();

    // Zero warm-up, single neuron, all-ones stream.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 1;
    while (!res_valid0 && n < 40) begin
      step();
      n++;
    end
    check("dut0_latency", n, 19);
    check("dut0_res_data", res_data0, 16);
    check("dut0_res_idx", res_idx0, 0);
    step();
    check("dut0_frame_done", {frame_done0, busy0}, 2'b10);
    step();
    check("dut0_frame_done_clear", frame_done0, 0);

    for (int f = 0; f < 2; f++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        v = vecs[f * 4 + i];
        run_neuron(v.mode, v.exp, i, v.wait_c, v.st_pulse, 0, i == 3);
      end
    end

    // Reset in the middle of neuron 2's RUN window, then a clean restart.
    start = 1'b1;
    step();
    start = 1'b0;
    run_neuron(1, 16, 0, 0, 1'b0, 0, 1'b0);
    run_neuron(1, 16, 1, 0, 1'b0, 0, 1'b0);
    run_neuron(1, 16, 2, 0, 1'b0, 10, 1'b0);
    step();
    check("reset_held", {busy, neuron_sel, res_valid, res_data}, 0);
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_neuron(4, 1, 0, 0, 1'b0, 0, 1'b0);
    run_neuron(0, 0, 1, 0, 1'b0, 0, 1'b0);
    run_neuron(6, 1, 2, 0, 1'b0, 0, 1'b0);
    run_neuron(1, 16, 3, 0, 1'b0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
